// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: fetch sequencer that owns the program counter.
//
// Issues one instruction-memory fetch at a time over a req/ack handshake.
// It holds the fetched word until the core consumes it, then selects the next PC
// from the exception, eret, jump, branch or sequential source.
//
// Ports:
//   Clk, Clrn            clock (posedge) and asynchronous active-low reset
//   imem_req/imem_addr   fetch request and address (address is always cur_pc)
//   imem_ack/imem_rdata  memory accept; read data valid in the same cycle
//   inst_valid/inst/     registered instruction word and its address
//   inst_pc
//   inst_ready           core consumes inst this cycle; qualifies all redirects
//   br_taken/br_target   taken branch for the consumed instruction
//   jmp/jmp_target       jump / jr for the consumed instruction
//   exc, eret            exception entry / return for the consumed instruction
//   halt                 stop fetching after the consumed instruction
//   epc                  saved exception PC
//   cur_pc               PC of the next fetch
//   halted               controller parked in HALT until reset
//
// Every output is a register or a decode of the registered state, so there is
// no combinational path from any input to any output.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] EXC_VEC   = 32'h0000_0080
) (
  input  logic        Clk,
  input  logic        Clrn,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp,
  input  logic [31:0] jmp_target,
  input  logic        exc,
  input  logic        eret,
  input  logic        halt,
  output logic [31:0] epc,
  output logic [31:0] cur_pc,
  output logic        halted
);

  typedef enum logic [1:0] {
    StBoot,
    StReq,
    StHold,
    StHalt
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic [31:0] epc_q, epc_d;

  logic [31:0] seq_pc;
  logic [31:0] raw_next_pc;
  logic [31:0] next_pc;

  // Next-PC select, highest priority first. Only used when an instruction
  // is consumed, so it can be computed unconditionally.
  always_comb begin
    seq_pc = inst_pc_q + 32'd4;  // wraps naturally at 2^32
    if (exc) begin
      raw_next_pc = EXC_VEC;
    end else if (eret) begin
      raw_next_pc = epc_q;
    end else if (jmp) begin
      raw_next_pc = jmp_target;
    end else if (br_taken) begin
      raw_next_pc = br_target;
    end else begin
      raw_next_pc = seq_pc;
    end
    // Word-align every source; misaligned targets are silently truncated.
    next_pc = raw_next_pc & ~32'h0000_0003;
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    epc_d     = epc_q;

    unique case (state_q)
      StBoot: begin
        // A stale ack left over from before reset is ignored here.
        state_d = StReq;
      end
      StReq: begin
        if (imem_ack) begin
          inst_d    = imem_rdata;
          inst_pc_d = pc_q;
          state_d   = StHold;
        end
      end
      StHold: begin
        // Redirect inputs are only meaningful while consuming.
        if (inst_ready) begin
          pc_d = next_pc;
          if (exc) begin
            epc_d = inst_pc_q;
          end
          state_d = halt ? StHalt : StReq;
        end
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StBoot;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      state_q   <= StBoot;
      pc_q      <= RESET_VEC;
      inst_q    <= 32'h0;
      inst_pc_q <= 32'h0;
      epc_q     <= 32'h0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      epc_q     <= epc_d;
    end
  end

  assign imem_req   = (state_q == StReq);
  assign imem_addr  = pc_q;
  assign cur_pc     = pc_q;
  assign inst_valid = (state_q == StHold);
  assign halted     = (state_q == StHalt);
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign epc        = epc_q;

endmodule
